// File: rtl/sr_ff_driver_pkg.sv
// Shared definitions for the SR flip-flop command driver: opcodes, FSM states
// and the S/R excitation rule.
package sr_ff_driver_pkg;

    typedef enum logic [1:0] {
        OP_HOLD = 2'b00,
        OP_CLR  = 2'b01,
        OP_SET  = 2'b10,
        OP_TGL  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_CHECK
    } state_e;

    // {S,R}: only one side is ever asserted, and only when Q must move.
    function automatic logic [1:0] sr_excite(input logic q, input logic target);
        return (q == target) ? 2'b00 : {target, ~target};
    endfunction

    function automatic logic op_target(input op_e op, input logic q);
        logic t;
        t = q;
        case (op)
            OP_HOLD: t = q;
            OP_CLR:  t = 1'b0;
            OP_SET:  t = 1'b1;
            OP_TGL:  t = ~q;
            default: t = q;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/sr_ff_driver_if.sv
// Command handshake, flip-flop feedback/excitation and status bundle for sr_ff_driver.
interface sr_ff_driver_if #(
    parameter int unsigned CNT_W = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic             q_fb;
    logic             S;
    logic             R;
    logic             busy;
    logic             done;
    logic             err;
    logic [CNT_W-1:0] err_count;

    modport master (
        output cmd_valid, cmd_op, q_fb,
        input  cmd_ready, S, R, busy, done, err, err_count
    );

    modport slave (
        input  cmd_valid, cmd_op, q_fb,
        output cmd_ready, S, R, busy, done, err, err_count
    );
endinterface

// File: rtl/sr_excitation.sv
// Combinational S/R derivation from current Q and target value; reusable by
// other flip-flop drivers.
module sr_excitation
    import sr_ff_driver_pkg::*;
(
    input  logic q_i,
    input  logic target_i,
    output logic s_o,
    output logic r_o,
    output logic need_drive_o
);
    assign {s_o, r_o}   = sr_excite(q_i, target_i);
    assign need_drive_o = q_i ^ target_i;
endmodule

// File: rtl/sr_ff_driver.sv
// Command-side controller for one SR flip-flop: accepts hold/clear/set/toggle,
// pulses the legal excitation, then confirms Q and reports done or err.
module sr_ff_driver
    import sr_ff_driver_pkg::*;
#(
    parameter int unsigned PULSE_CYCLES = 1,
    parameter int unsigned TIMEOUT      = 4,
    parameter int unsigned CNT_W        = 8
) (
    input  logic           clk,
    input  logic           rst,
    sr_ff_driver_if.slave  bus
);
    localparam int unsigned PW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_e           state_q;
    logic             target_q;
    logic [PW-1:0]    pcnt_q;
    logic [TW-1:0]    ccnt_q;
    logic             s_q, r_q, busy_q, done_q, err_q;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic             target_d;
    logic             exc_s, exc_r, need_drive;

    assign target_d  = op_target(op_e'(bus.cmd_op), bus.q_fb);
    assign err_cnt_d = (err_cnt_q == '1) ? err_cnt_q : err_cnt_q + CNT_W'(1);

    sr_excitation u_exc (
        .q_i          (bus.q_fb),
        .target_i     (target_d),
        .s_o          (exc_s),
        .r_o          (exc_r),
        .need_drive_o (need_drive)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            target_q  <= 1'b0;
            pcnt_q    <= '0;
            ccnt_q    <= '0;
            s_q       <= 1'b0;
            r_q       <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // cmd_ready is high throughout IDLE, so valid alone is a handshake.
                    if (bus.cmd_valid) begin
                        target_q <= target_d;
                        busy_q   <= 1'b1;
                        s_q      <= exc_s;
                        r_q      <= exc_r;
                        pcnt_q   <= '0;
                        ccnt_q   <= '0;
                        state_q  <= need_drive ? ST_DRIVE : ST_CHECK;
                    end
                end
                ST_DRIVE: begin
                    if (pcnt_q == PW'(PULSE_CYCLES - 1)) begin
                        s_q     <= 1'b0;
                        r_q     <= 1'b0;
                        ccnt_q  <= '0;
                        state_q <= ST_CHECK;
                    end else begin
                        pcnt_q <= pcnt_q + PW'(1);
                    end
                end
                ST_CHECK: begin
                    if (bus.q_fb == target_q) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (ccnt_q == TW'(TIMEOUT - 1)) begin
                        err_q     <= 1'b1;
                        busy_q    <= 1'b0;
                        err_cnt_q <= err_cnt_d;
                        state_q   <= ST_IDLE;
                    end else begin
                        ccnt_q <= ccnt_q + TW'(1);
                    end
                end
                default: begin
                    s_q     <= 1'b0;
                    r_q     <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready = (state_q == ST_IDLE);
    assign bus.S         = s_q;
    assign bus.R         = r_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.err_count = err_cnt_q;
endmodule

// File: tb/tb_sr_ff_driver.sv
// Bench for sr_ff_driver driving a behavioural SR flip-flop, with a
// timeline-based reference model and directed literal expectations.
module tb_sr_ff_driver;
    localparam int unsigned P  = 1;
    localparam int unsigned TO = 4;
    localparam int unsigned CW = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    sr_ff_driver_if #(.CNT_W(CW)) bus ();

    sr_ff_driver #(.PULSE_CYCLES(P), .TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // The driven SR flip-flop with its own async reset; q_fb can be pinned low.
    logic ff_rst_n = 1'b0;
    logic ff_q;
    logic force_lo = 1'b0;
    always_ff @(posedge clk or negedge ff_rst_n) begin
        if (!ff_rst_n)              ff_q <= 1'b0;
        else if (bus.S && !bus.R)   ff_q <= 1'b1;
        else if (bus.R && !bus.S)   ff_q <= 1'b0;
    end
    assign bus.q_fb = force_lo ? 1'b0 : ff_q;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: each accepted command expands into a list of output
    // records, one per clock edge, from the accept edge to the done/err edge.
    typedef struct packed {
        logic s;
        logic r;
        logic busy;
        logic done;
        logic err;
    } rec_t;

    rec_t   tl[$];
    rec_t   exp_r = '0;
    int     exp_cnt = 0;
    logic   v_s = 1'b0;
    logic [1:0] op_s = 2'b00;
    logic   q_s = 1'b0;

    always @(negedge clk) begin
        v_s  = bus.cmd_valid;
        op_s = bus.cmd_op;
        q_s  = bus.q_fb;
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            tl.delete();
            exp_r   = '0;
            exp_cnt = 0;
        end else begin
            if (tl.size() == 0 && v_s) begin
                logic t, ok;
                int   m;
                t  = (op_s == 2'd0) ? q_s : (op_s == 2'd1) ? 1'b0 : (op_s == 2'd2) ? 1'b1 : !q_s;
                ok = force_lo ? (t == 1'b0) : 1'b1;
                m  = ok ? 1 : int'(TO);
                if (t != q_s)
                    for (int i = 0; i < int'(P); i++) tl.push_back('{t, !t, 1'b1, 1'b0, 1'b0});
                tl.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
                for (int i = 0; i < m - 1; i++) tl.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
                tl.push_back('{1'b0, 1'b0, 1'b0, ok, !ok});
            end
            if (tl.size() != 0) begin
                exp_r = tl.pop_front();
                if (exp_r.err && exp_cnt < (1 << CW) - 1) exp_cnt++;
            end else begin
                exp_r = '0;
            end
        end
    end

    always @(negedge clk) begin
        check("S",         32'(bus.S),         32'(exp_r.s));
        check("R",         32'(bus.R),         32'(exp_r.r));
        check("busy",      32'(bus.busy),      32'(exp_r.busy));
        check("done",      32'(bus.done),      32'(exp_r.done));
        check("err",       32'(bus.err),       32'(exp_r.err));
        check("err_count", 32'(bus.err_count), 32'(exp_cnt));
        check("cmd_ready", 32'(bus.cmd_ready), 32'(tl.size() == 0));
        check("S_and_R",   32'(bus.S & bus.R), 32'd0);
    end

    task automatic send(input logic [1:0] op);
        @(posedge clk);
        #2;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        rst      = 1'b0;
        ff_rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst      = 1'b1;
        ff_rst_n = 1'b1;
        @(negedge clk);
        check("rst_S", 32'(bus.S), 0);
        check("rst_R", 32'(bus.R), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_err", 32'(bus.err), 0);
        check("rst_cnt", 32'(bus.err_count), 0);
        check("rst_ready", 32'(bus.cmd_ready), 1);

        // Set from Q=0
        send(2'b10);
        check("set_S", 32'(bus.S), 1);
        check("set_R", 32'(bus.R), 0);
        check("set_busy", 32'(bus.busy), 1);
        step();
        check("set_S_off", 32'(bus.S), 0);
        check("set_q", 32'(bus.q_fb), 1);
        check("set_done_early", 32'(bus.done), 0);
        step();
        check("set_done", 32'(bus.done), 1);
        check("set_busy_off", 32'(bus.busy), 0);
        check("set_ready", 32'(bus.cmd_ready), 1);
        step();
        check("set_done_pulse", 32'(bus.done), 0);

        // Toggle twice from Q=1
        send(2'b11);
        check("tgl1_R", 32'(bus.R), 1);
        check("tgl1_S", 32'(bus.S), 0);
        step(); step();
        check("tgl1_done", 32'(bus.done), 1);
        check("tgl1_q", 32'(bus.q_fb), 0);
        send(2'b11);
        check("tgl2_S", 32'(bus.S), 1);
        check("tgl2_R", 32'(bus.R), 0);
        step(); step();
        check("tgl2_done", 32'(bus.done), 1);
        check("tgl2_q", 32'(bus.q_fb), 1);

        // Already at target: set and hold with Q=1
        send(2'b10);
        check("nop_set_S", 32'(bus.S), 0);
        check("nop_set_busy", 32'(bus.busy), 1);
        step();
        check("nop_set_done", 32'(bus.done), 1);
        send(2'b00);
        check("hold_R", 32'(bus.R), 0);
        step();
        check("hold_done", 32'(bus.done), 1);

        // Timeout with q_fb pinned low
        @(posedge clk); #2 force_lo = 1'b1;
        send(2'b10);
        check("to_S", 32'(bus.S), 1);
        step();
        check("to_S_off", 32'(bus.S), 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("to_err_early", 32'(bus.err), 0);
        end
        step();
        check("to_err", 32'(bus.err), 1);
        check("to_cnt", 32'(bus.err_count), 1);
        step();
        check("to_err_pulse", 32'(bus.err), 0);
        @(posedge clk); #2 force_lo = 1'b0;

        // Random commands, flip-flop following S/R
        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #2;
            bus.cmd_valid = 1'($urandom_range(0, 1));
            bus.cmd_op    = 2'($urandom_range(0, 3));
        end
        bus.cmd_valid = 1'b0;
        repeat (12) @(posedge clk);
        #2 force_lo = 1'b1;

        // Random commands with Q stuck low
        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #2;
            bus.cmd_valid = 1'($urandom_range(0, 1));
            bus.cmd_op    = 2'($urandom_range(0, 3));
        end
        bus.cmd_valid = 1'b0;
        repeat (12) @(posedge clk);

        // Drive the error counter into saturation
        #2;
        bus.cmd_op    = 2'b10;
        bus.cmd_valid = 1'b1;
        repeat (300 * 6) @(posedge clk);
        #2 bus.cmd_valid = 1'b0;
        repeat (10) step();
        check("sat_cnt", 32'(bus.err_count), 255);

        // Reset during DRIVE
        @(posedge clk); #2;
        force_lo = 1'b0;
        ff_rst_n = 1'b0;
        #1 ff_rst_n = 1'b1;
        send(2'b10);
        check("mid_S", 32'(bus.S), 1);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_S", 32'(bus.S), 0);
        check("mid_rst_R", 32'(bus.R), 0);
        check("mid_rst_busy", 32'(bus.busy), 0);
        check("mid_rst_cnt", 32'(bus.err_count), 0);
        check("mid_rst_ready", 32'(bus.cmd_ready), 1);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        step();
        check("mid_no_done", 32'(bus.done), 0);
        check("mid_no_err", 32'(bus.err), 0);
        send(2'b10);
        check("post_S", 32'(bus.S), 1);
        step(); step();
        check("post_done", 32'(bus.done), 1);
        check("post_cnt", 32'(bus.err_count), 0);

        repeat (3) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sr_ff_driver.md
Name: sr_ff_driver

Overview:
- Command-side controller for a single clocked SR flip-flop: the block that generates S/R excitation rather than consuming it.
- Accepts set / clear / toggle / hold commands over a valid/ready handshake.
- Derives the legal S/R excitation from the flip-flop's Q feedback and the target value, then pulses it.
- Confirms Q reached the target and reports done or error; it can never emit the forbidden S=R=1 combination.

Parameters:
PULSE_CYCLES, 1, cycles S or R is held asserted per command (>=1)
TIMEOUT, 4, maximum CHECK-state sampling edges before error (>=1)
CNT_W, 8, width of saturating error counter

Ports:
clk  input  1  clock, rising-edge
rst  input  1  asynchronous, active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  block can accept a command
cmd_op  input  2  00 hold, 01 clear, 10 set, 11 toggle
q_fb  input  1  Q of the driven flip-flop
S  output  1  set excitation to the flip-flop
R  output  1  reset excitation to the flip-flop
busy  output  1  command in progress
done  output  1  one-cycle pulse: Q matched target
err  output  1  one-cycle pulse: timeout, Q never matched
err_count  output  CNT_W  saturating count of err pulses

Behaviour:
- Reset (rst=0, asynchronous):
  - S=0, R=0, done=0, err=0, busy=0, err_count=0, state=IDLE.
  - cmd_ready=1 once rst deasserts.
  - A command in flight is discarded, with no done or err.
- All outputs except cmd_ready are registered. cmd_ready = (state==IDLE), combinational.
- States: IDLE, DRIVE, CHECK.
- IDLE:
  - A handshake (cmd_valid & cmd_ready) at edge k captures target:
    - hold: target = q_fb
    - clear: target = 0
    - set: target = 1
    - toggle: target = ~q_fb
  - q_fb is sampled at edge k.
  - If target==q_fb: S=R=0, go to CHECK.
  - Else: S=target, R=~target, pulse counter=0, go to DRIVE. busy=1 from edge k.
  - cmd_valid with no handshake has no effect.
- DRIVE:
  - S/R held constant for PULSE_CYCLES cycles.
  - At edge k+PULSE_CYCLES: S=R=0, go to CHECK, check counter=0.
- CHECK: at each edge, compare q_fb to target.
  - Match: done=1 for one cycle, busy=0, go to IDLE.
  - Mismatch: increment the check counter. On the TIMEOUT-th mismatching edge: err=1 for one cycle, err_count+1 (saturating at all-ones), busy=0, go to IDLE.
- Latency with PULSE_CYCLES=1 and a flip-flop that updates at the edge where S/R is sampled:
  - Accept at edge k, done rises at edge k+2.
  - No-drive case (already at target): done rises at edge k+1.
- Invariant: S&R==0 in every cycle, including reset and mid-operation. S and R are never both asserted.
- cmd_op and cmd_valid are ignored while busy. No queuing.
- A new command may be accepted at the edge after done or err, since IDLE is re-entered at that edge.
- Flip-flop reset asserted externally during DRIVE/CHECK is simply seen as q_fb: matching target gives done, otherwise the timeout path gives err.

Decomposition:
- Shared package holds:
  - op encodings OP_HOLD=2'b00, OP_CLR=2'b01, OP_SET=2'b10, OP_TGL=2'b11
  - state encodings ST_IDLE, ST_DRIVE, ST_CHECK
  - the excitation rule as a function: (q, target) -> {S,R}
- One natural sub-module: sr_excitation, the combinational S/R derivation (q, target -> S, R, need_drive), reusable by a future JK/T driver.
- Bench instantiates sr_ff_driver plus the existing SR flip-flop with async reset, with Q wired to q_fb.

Test Plan:
- Reset then idle: rst=0 for 2 cycles, release -> S=R=0, done=err=0, err_count=0, cmd_ready=1.
- Set from Q=0: cmd_op=10 at edge k -> S=1,R=0 during cycle k..k+1, Q=1 after edge k+1, done pulse at k+2, err_count=0.
- Toggle twice from Q=1: toggle gives R pulse, Q=0, done. Second toggle gives S pulse, Q=1, done. No cycle ever has S=R=1.
- Hold / already-at-target: Q=1, cmd_op=10 -> S,R stay 0, done at k+1. Repeat with cmd_op=00 -> same.
- Timeout: q_fb forced to 0, cmd_op=10, TIMEOUT=4 -> err pulse after 4 CHECK edges, err_count=1. Repeat 300 times with CNT_W=8 -> err_count saturates at 255.
- Reset mid-operation: assert rst during DRIVE with S=1 -> S drops to 0 asynchronously before the next edge, no done or err. After release, cmd_ready=1 and the next set command completes normally.
